hestoneuro_mul_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed-width combinational multiplier cores in hestonEuro.
- Runtime per-operand signed/unsigned mode, configurable pipeline depth, and valid/ready flow control with backpressure.
- Optional right-shift and narrowing of the product.
- Sits between the path-simulation datapath and the payoff accumulator, where the single-cycle multiply limits timing.

---
 rtl/hestoneuro_mul_pipe.sv | 147 ++++++++++++++
 tb/tb_hestoneuro_mul_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hestoneuro_mul_pipe.sv
// hestoneuro_mul_pipe: pipelined multiplier with per-beat signed/unsigned mode,
// an optional arithmetic right shift, narrowing with overflow detection, and
// valid/ready flow control.
// Optional feature macro: HESTONEURO_MUL_SAT_EN. When it is defined, dout clamps
// to its format's limits on overflow. When it is undefined, dout wraps.
// Stage layout for NUM_STAGE >= 2: stage 0 holds the raw operands and stage 1
// holds the product. Later stages are plain delay stages. For NUM_STAGE == 1,
// the single stage captures the finished result.
module hestoneuro_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 15,
  parameter int din1_WIDTH = 15,
  parameter int dout_WIDTH = 30,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  sgn0,
  input  logic                  sgn1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int FULL = din0_WIDTH + din1_WIDTH;
  // Number of stages that carry the finished {ovf, dout} word.
  localparam int RS   = (NUM_STAGE == 1) ? 1 : NUM_STAGE - 1;

  if (NUM_STAGE < 1 || NUM_STAGE > 8 || dout_WIDTH < 1 || dout_WIDTH > FULL ||
      SHIFT < 0 || SHIFT >= FULL || ID < 0) begin : g_param_check
    $error("hestoneuro_mul_pipe: illegal parameter combination");
  end

`ifdef HESTONEURO_MUL_SAT_EN
  // Clamp to the format limit when significant bits were lost.
  function automatic logic [dout_WIDTH-1:0] saturate(
    input logic [dout_WIDTH-1:0] res,
    input logic                  lost,
    input logic                  is_signed,
    input logic                  neg
  );
    logic [dout_WIDTH-1:0] umax;
    logic [dout_WIDTH-1:0] smax;
    umax = '1;
    smax = umax >> 1;
    if (!lost)
      return res;
    if (!is_signed)
      return umax;
    return neg ? ~smax : smax;
  endfunction
`endif

  // Extend, multiply, scale and narrow one beat. The result is {ovf, dout}.
  // Extending both operands straight to FULL bits makes the FULL-bit truncated
  // product exact in every sign mode.
  function automatic logic [dout_WIDTH:0] mul_scale(
    input logic [din0_WIDTH-1:0] a,
    input logic [din1_WIDTH-1:0] b,
    input logic                  sa,
    input logic                  sb
  );
    logic signed [FULL-1:0] ax;
    logic signed [FULL-1:0] bx;
    logic signed [FULL-1:0] prod;
    logic signed [FULL-1:0] r;
    logic [dout_WIDTH-1:0]  res;
    logic                   is_signed;
    logic                   lost;
    ax        = {{din1_WIDTH{sa & a[din0_WIDTH-1]}}, a};
    bx        = {{din0_WIDTH{sb & b[din1_WIDTH-1]}}, b};
    prod      = ax * bx;
    is_signed = sa | sb;
    r         = is_signed ? (prod >>> SHIFT) : (prod >> SHIFT);
    res       = r[dout_WIDTH-1:0];
    lost      = 1'b0;
    for (int i = dout_WIDTH; i < FULL; i++)
      lost = lost | (is_signed ? (r[i] ^ r[dout_WIDTH-1]) : r[i]);
`ifdef HESTONEURO_MUL_SAT_EN
    res = saturate(res, lost, is_signed, r[FULL-1]);
`endif
    return {lost, res};
  endfunction

  logic                  advance;
  logic [NUM_STAGE-1:0]  vld_p;
  logic [dout_WIDTH:0]   res_p [RS];
  logic [dout_WIDTH:0]   calc;

  assign out_valid = vld_p[NUM_STAGE-1];
  assign advance   = ce & (~out_valid | out_ready);
  assign in_ready  = advance;
  assign dout      = res_p[RS-1][dout_WIDTH-1:0];
  assign ovf       = res_p[RS-1][dout_WIDTH];

  if (NUM_STAGE == 1) begin : g_single
    assign calc = mul_scale(din0, din1, sgn0, sgn1);
  end else begin : g_multi
    logic [din0_WIDTH-1:0] op0_p0;
    logic [din1_WIDTH-1:0] op1_p0;
    logic                  sgn0_p0;
    logic                  sgn1_p0;

    // Stage 0: capture the raw operands and their modes.
    always_ff @(posedge clk) begin
      if (advance) begin
        op0_p0  <= din0;
        op1_p0  <= din1;
        sgn0_p0 <= sgn0;
        sgn1_p0 <= sgn1;
      end
    end

    assign calc = mul_scale(op0_p0, op1_p0, sgn0_p0, sgn1_p0);
  end

  // Valid bits shift with the data. Reset drops every beat in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else if (advance) begin
      for (int i = NUM_STAGE - 1; i > 0; i--)
        vld_p[i] <= vld_p[i-1];
      vld_p[0] <= in_valid;
    end
  end

  // Result stages: load the computed word, then delay it to the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RS; i++)
        res_p[i] <= '0;
    end else if (advance) begin
      for (int i = RS - 1; i > 0; i--)
        res_p[i] <= res_p[i-1];
      res_p[0] <= calc;
    end
  end

endmodule

// File: tb/tb_hestoneuro_mul_pipe.sv
// Scoreboard bench for hestoneuro_mul_pipe. Three instances share the stimulus:
// A uses the defaults, B uses dout_WIDTH=16, and C uses SHIFT=4 with dout_WIDTH=26.
module tb_hestoneuro_mul_pipe;

  typedef struct {
    logic [31:0] d;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic reset, ce, in_valid, out_ready, sgn0, sgn1;
  logic [14:0] din0, din1;
  logic in_ready_a, in_ready_b, in_ready_c;
  logic out_valid_a, out_valid_b, out_valid_c;
  logic ovf_a, ovf_b, ovf_c;
  logic [29:0] dout_a;
  logic [15:0] dout_b;
  logic [25:0] dout_c;

  int checks = 0;
  int failures = 0;
  exp_t qa[$], qb[$], qc[$];
  logic held_v = 1'b0;
  logic [29:0] held_d;
  logic held_o;

  always #5 clk = ~clk;

  hestoneuro_mul_pipe #(.ID(1), .NUM_STAGE(3), .din0_WIDTH(15), .din1_WIDTH(15),
                        .dout_WIDTH(30), .SHIFT(0)) u_a (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_a),
    .din0(din0), .din1(din1), .sgn0(sgn0), .sgn1(sgn1), .out_valid(out_valid_a),
    .out_ready(out_ready), .dout(dout_a), .ovf(ovf_a));

  hestoneuro_mul_pipe #(.ID(2), .NUM_STAGE(3), .din0_WIDTH(15), .din1_WIDTH(15),
                        .dout_WIDTH(16), .SHIFT(0)) u_b (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_b),
    .din0(din0), .din1(din1), .sgn0(sgn0), .sgn1(sgn1), .out_valid(out_valid_b),
    .out_ready(out_ready), .dout(dout_b), .ovf(ovf_b));

  hestoneuro_mul_pipe #(.ID(3), .NUM_STAGE(3), .din0_WIDTH(15), .din1_WIDTH(15),
                        .dout_WIDTH(26), .SHIFT(4)) u_c (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_c),
    .din0(din0), .din1(din1), .sgn0(sgn0), .sgn1(sgn1), .out_valid(out_valid_c),
    .out_ready(out_ready), .dout(dout_c), .ovf(ovf_c));

  // Reference model: exact integer product, floor shift, range-based overflow.
  function automatic exp_t model(input int w, input int sh, input logic [14:0] a,
                                 input logic [14:0] b, input logic s0, input logic s1);
    exp_t e;
    longint va, vb, p, r, lim, mask;
    va   = s0 ? longint'($signed(a)) : longint'(a);
    vb   = s1 ? longint'($signed(b)) : longint'(b);
    p    = va * vb;
    r    = p >>> sh;
    lim  = longint'(1) <<< (w - 1);
    mask = (longint'(1) <<< w) - 1;
    if (s0 | s1) e.ov = (r < -lim) || (r >= lim);
    else         e.ov = (r > mask);
    e.d = 32'(r & mask);
`ifdef HESTONEURO_MUL_SAT_EN
    if (e.ov) begin
      if (s0 | s1) e.d = (r < 0) ? 32'(lim) : 32'(lim - 1);
      else         e.d = 32'(mask);
    end
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_pop(input string name, input logic have, input exp_t e,
                           input logic [31:0] d, input logic o);
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s unexpected output actual=0x%0h required=none at %0t", name, d, $time);
    end else if (d !== e.d || o !== e.ov) begin
      failures++;
      $display("FAIL %s actual=0x%0h/ovf%0b required=0x%0h/ovf%0b at %0t",
               name, d, o, e.d, e.ov, $time);
    end
  endtask

  // Monitor: mid-cycle sampling of the transfers that the next rising edge will perform.
  always @(negedge clk) begin
    exp_t e;
    logic have;
    if (reset) begin
      held_v = 1'b0;
    end else begin
      check("in_ready_a", 32'(in_ready_a), 32'(ce && (!out_valid_a || out_ready)));
      if (held_v && out_valid_a) begin
        check("stall_hold_dout", 32'(dout_a), 32'(held_d));
        check("stall_hold_ovf", 32'(ovf_a), 32'(held_o));
      end
      held_v = out_valid_a && !(out_ready && ce);
      held_d = dout_a;
      held_o = ovf_a;
      if (out_valid_a && out_ready && ce) begin
        have = qa.size() > 0;
        if (have) e = qa.pop_front();
        check_pop("out_a", have, e, 32'(dout_a), ovf_a);
      end
      if (out_valid_b && out_ready && ce) begin
        have = qb.size() > 0;
        if (have) e = qb.pop_front();
        check_pop("out_b", have, e, 32'(dout_b), ovf_b);
      end
      if (out_valid_c && out_ready && ce) begin
        have = qc.size() > 0;
        if (have) e = qc.pop_front();
        check_pop("out_c", have, e, 32'(dout_c), ovf_c);
      end
      if (in_valid && in_ready_a) qa.push_back(model(30, 0, din0, din1, sgn0, sgn1));
      if (in_valid && in_ready_b) qb.push_back(model(16, 0, din0, din1, sgn0, sgn1));
      if (in_valid && in_ready_c) qc.push_back(model(26, 4, din0, din1, sgn0, sgn1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one beat to an idle pipeline, optionally freeze ce after acceptance,
  // and report the instance outputs plus the edge count until out_valid.
  task automatic single_beat(input logic [14:0] a, input logic [14:0] b, input logic s0,
                             input logic s1, input int ce_gap, output logic [29:0] da,
                             output logic [15:0] db, output logic [25:0] dc,
                             output logic oa, output logic ob, output logic oc,
                             output int lat);
    din0 = a; din1 = b; sgn0 = s0; sgn1 = s1;
    in_valid = 1'b1; out_ready = 1'b1; ce = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    if (ce_gap > 0) begin
      ce = 1'b0;
      repeat (ce_gap) begin
        tick();
        lat++;
      end
      ce = 1'b1;
    end
    while (!out_valid_a && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid_a) begin
      failures++;
      $display("FAIL timeout waiting for out_valid actual=0 required=1");
    end
    da = dout_a; db = dout_b; dc = dout_c;
    oa = ovf_a;  ob = ovf_b;  oc = ovf_c;
  endtask

  initial begin
    logic [29:0] da;
    logic [15:0] db;
    logic [25:0] dc;
    logic oa, ob, oc;
    int lat, idx, cyc, seen;
    logic acc;

    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sgn0 = 1'b0; sgn1 = 1'b0; din0 = '0; din1 = '0;
    repeat (3) tick();
    check("reset_out_valid", 32'({out_valid_a, out_valid_b, out_valid_c}), 32'h0);
    check("reset_dout_a", 32'(dout_a), 32'h0);
    check("reset_ovf", 32'({ovf_a, ovf_b, ovf_c}), 32'h0);
    reset = 1'b0;
    tick();

    single_beat(15'h7FFF, 15'h7FFF, 1'b0, 1'b0, 0, da, db, dc, oa, ob, oc, lat);
    check("uu_max_dout", 32'(da), 32'h3FFF0001);
    check("uu_max_ovf", 32'(oa), 32'h0);
    check("uu_max_latency", 32'(lat), 32'd2);

    single_beat(15'h7FFF, 15'h0003, 1'b1, 1'b1, 0, da, db, dc, oa, ob, oc, lat);
    check("ss_neg1x3", 32'(da), 32'h3FFFFFFD);
    single_beat(15'h7FFF, 15'h0003, 1'b1, 1'b0, 0, da, db, dc, oa, ob, oc, lat);
    check("su_neg1x3", 32'(da), 32'h3FFFFFFD);
    single_beat(15'h0002, 15'h7FFF, 1'b0, 1'b1, 0, da, db, dc, oa, ob, oc, lat);
    check("us_2xneg1", 32'(da), 32'h3FFFFFFE);

    single_beat(15'd300, 15'd300, 1'b0, 1'b0, 0, da, db, dc, oa, ob, oc, lat);
`ifdef HESTONEURO_MUL_SAT_EN
    check("narrow_300x300_dout", 32'(db), 32'hFFFF);
`else
    check("narrow_300x300_dout", 32'(db), 32'h5F90);
`endif
    check("narrow_300x300_ovf", 32'(ob), 32'h1);
    single_beat(15'd200, 15'd300, 1'b0, 1'b0, 0, da, db, dc, oa, ob, oc, lat);
    check("narrow_200x300_dout", 32'(db), 32'hEA60);
    check("narrow_200x300_ovf", 32'(ob), 32'h0);

    single_beat(15'h7FF0, 15'h0001, 1'b1, 1'b1, 0, da, db, dc, oa, ob, oc, lat);
    check("shift4_dout", 32'(dc), 32'h3FFFFFF);
    check("shift4_ovf", 32'(oc), 32'h0);

    single_beat(15'd7, 15'd9, 1'b0, 1'b0, 5, da, db, dc, oa, ob, oc, lat);
    check("ce_gap_latency", 32'(lat), 32'd7);
    check("ce_gap_dout", 32'(da), 32'd63);
    tick();

    // Back-to-back beats with a 4-cycle downstream stall.
    idx = 1; cyc = 0; sgn0 = 1'b0; sgn1 = 1'b0; din1 = 15'd10; ce = 1'b1;
    while (idx <= 6 && cyc < 60) begin
      din0 = 15'(idx);
      in_valid = 1'b1;
      out_ready = !(cyc >= 3 && cyc < 7);
      #1;
      if (cyc == 3) check("in_ready_drop", 32'(in_ready_a), 32'h0);
      acc = in_ready_a;
      tick();
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    check("stream_drained", 32'(qa.size()), 32'h0);

    // Asynchronous reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din0 = 15'(i + 11); din1 = 15'd3; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    qa.delete(); qb.delete(); qc.delete();
    #1;
    check("async_reset_out_valid", 32'({out_valid_a, out_valid_b, out_valid_c}), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      tick();
      if (out_valid_a) seen++;
    end
    check("no_beat_after_reset", 32'(seen), 32'h0);

    // Randomized traffic with ce and out_ready toggling.
    for (int n = 0; n < 400; n++) begin
      ce        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      sgn0      = 1'($urandom_range(0, 1));
      sgn1      = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       begin din0 = 15'h7FFF; din1 = 15'h7FFF; end
        1:       begin din0 = 15'h4000; din1 = 15'h4000; end
        2:       begin din0 = 15'h0000; din1 = 15'($urandom); end
        default: begin din0 = 15'($urandom); din1 = 15'($urandom); end
      endcase
      tick();
    end
    in_valid = 1'b0; ce = 1'b1; out_ready = 1'b1;
    cyc = 0;
    while ((qa.size() > 0 || qb.size() > 0 || qc.size() > 0) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("final_queue_a", 32'(qa.size()), 32'h0);
    check("final_queue_b", 32'(qb.size()), 32'h0);
    check("final_queue_c", 32'(qc.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
